running_min: RTL and testbench

RUNNING_MIN -- requirements
Module: running_min

---
 rtl/running_min_pkg.sv | 27 ++
 rtl/lesser.sv | 15 +
 rtl/running_min.sv | 97 +++++++++
 tb/tb_running_min.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/running_min_pkg.sv
// Shared definitions for running_min: FSM state encoding and frame-length rule.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package running_min_pkg;

    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // A programmed length of 0 encodes a full 16-sample frame.
    function automatic logic [LEN_W:0] frame_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? (LEN_W+1)'(16) : {1'b0, len};
    endfunction

    // Counter value at which the final sample of the frame is accepted.
    // For a 16-sample frame this wraps to 15.
    function automatic logic [LEN_W-1:0] last_index(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] n;
        n = frame_len(len) - (LEN_W+1)'(1);
        return n[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/lesser.sv
// Strict unsigned less-than comparator: o = 1 iff x < y.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y - unsigned operands; o - comparison result.
module lesser #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             o
);

    assign o = (x < y);

endmodule

// File: rtl/running_min.sv
// Finds the minimum sample (and its first position) over a frame of 1-16 samples.
// Latency: result valid the cycle after the last sample is accepted.
// Backpressure: result held in REPORT until out_ready; in_ready low outside ACCUM.
// Ports: start/len begin a frame; in_valid/in_data/in_ready sample stream;
//        out_valid/out_min/out_idx/out_ready result handshake; busy = not IDLE.
module running_min
    import running_min_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_min,
    output logic [3:0]       out_idx,
    input  logic             out_ready,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       len_q, len_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [3:0]       idx_q, idx_d;
    logic             is_less;

    lesser #(.WIDTH(WIDTH)) u_lesser (
        .x (in_data),
        .y (min_q),
        .o (is_less)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        min_d   = min_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    // First sample seeds the minimum; later ones must be strictly
                    // smaller so that ties keep the earliest index.
                    if (cnt_q == '0 || is_less) begin
                        min_d = in_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == last_index(len_q)) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_REPORT);
    assign busy      = (state_q != ST_IDLE);
    assign out_min   = min_q;
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_running_min.sv
module tb_running_min;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_min;
    logic [3:0] out_idx;
    logic       out_ready;
    logic       busy;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] i;
    } res_t;

    res_t       exp_q[$];
    logic [3:0] smp [16];
    int         n_cmp = 0;
    int         n_bad = 0;

    running_min #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_min   (out_min),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one complete frame from smp[0..n-1]; expected result comes from a
    // reference scan in the bench and travels through the scoreboard queue.
    task automatic do_frame(input logic [3:0] l, input bit gaps, input int hold,
                            input bit start_in_report);
        int   n;
        res_t e;
        res_t r;
        n   = (l == 4'd0) ? 16 : int'(l);
        e.m = smp[0];
        e.i = 4'd0;
        for (int k = 1; k < n; k++) begin
            if (smp[k] < e.m) begin
                e.m = smp[k];
                e.i = 4'(k);
            end
        end
        exp_q.push_back(e);

        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = ~l;
        check("busy_after_start", busy, 1);
        check("in_ready_accum", in_ready, 1);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                tick();
                check("gap_no_out_valid", out_valid, 0);
                check("gap_in_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data  = smp[k];
            if (k == n - 1) check("no_early_out_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        check("latency_out_valid", out_valid, 1);
        check("report_in_ready", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = (start_in_report && h == 1);
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_min", out_min, e.m);
            check("hold_out_idx", out_idx, e.i);
        end
        start     = start_in_report;
        out_ready = 1'b1;
        r = exp_q.pop_front();
        check("out_valid_hs", out_valid, 1);
        check("out_min", out_min, r.m);
        check("out_idx", out_idx, r.i);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 0);
        tick();
        check("idle_stays_idle", busy, 0);
        check("idle_hold_min", out_min, r.m);
        check("idle_hold_idx", out_idx, r.i);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_min", out_min, 0);
        check("rst_out_idx", out_idx, 0);

        // First start on the first edge with reset released; includes a tie.
        rst_n  = 1'b1;
        smp[0] = 4'd9; smp[1] = 4'd3; smp[2] = 4'd7; smp[3] = 4'd3;
        do_frame(4'd4, 1'b0, 0, 1'b0);

        // Full 16-sample frame, descending values.
        for (int k = 0; k < 16; k++) smp[k] = 4'(15 - k);
        do_frame(4'd0, 1'b0, 0, 1'b0);

        // Single-sample frame.
        smp[0] = 4'd15;
        do_frame(4'd1, 1'b0, 0, 1'b0);

        // Input gaps, 5-cycle consumer stall, start pulses during REPORT.
        smp[0] = 4'd5; smp[1] = 4'd2; smp[2] = 4'd8;
        do_frame(4'd3, 1'b1, 5, 1'b1);

        // Reset two samples into a four-sample frame.
        start = 1'b1;
        len   = 4'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd5;
        tick();
        in_data = 4'd1;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_min", out_min, 0);
        check("midrst_out_idx", out_idx, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (4) begin
            tick();
            check("postrst_no_out_valid", out_valid, 0);
        end
        smp[0] = 4'd6; smp[1] = 4'd4;
        do_frame(4'd2, 1'b0, 0, 1'b0);

        // A few random frames with gaps and short stalls.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) smp[k] = 4'($urandom);
            do_frame(4'($urandom_range(0, 15)), f[0], f + 1, 1'b1);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
